// File: rtl/xor_cipher_sequencer.sv
// -----------------------------------------------------------------------------
// xor_cipher_sequencer
//
// Front-end controller for the serial XOR cipher core. A key/message pair is
// accepted over a valid/ready handshake and shifted into the core MSB first:
// key first, then message. The core is then enabled. Its framed serial output
// is collected into a parallel result, and that result is offered over a second
// valid/ready handshake. This block is the only driver of the core's load and
// enable strobes.
//
// Optional feature macro: XSEQ_TIMEOUT_EN
//   When defined, RUN aborts after TIMEOUT cycles without an end of frame.
//   On abort, oTimeout pulses for one cycle and the block returns to IDLE.
//   When undefined, RUN waits indefinitely and oTimeout is tied low.
//
// Ports
//   iClk, iRst            clock (rising edge); asynchronous active-high reset
//   iKey, iMsg            key and message, sampled on request accept
//   iReq_valid/oReq_ready request handshake (ready only in IDLE)
//   oRes_data/oRes_valid  result word and valid (valid in DONE)
//   iRes_ready            consumer accepts the result
//   oCipher_serial        serial bit to the core, MSB first
//   oCipher_load_key      key-load strobe to the core
//   oCipher_load_msg      message-load strobe to the core
//   oCipher_en            core enable
//   iCipher_serial        serial output from the core
//   iCipher_start         core first-bit marker
//   iCipher_end           core last-bit marker
//   oBusy                 high in every state except IDLE
//   oTimeout              one-cycle pulse on a RUN abort
// -----------------------------------------------------------------------------
module xor_cipher_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iKey,
  input  logic [WIDTH-1:0] iMsg,
  input  logic             iReq_valid,
  output logic             oReq_ready,
  output logic [WIDTH-1:0] oRes_data,
  output logic             oRes_valid,
  input  logic             iRes_ready,
  output logic             oCipher_serial,
  output logic             oCipher_load_key,
  output logic             oCipher_load_msg,
  output logic             oCipher_en,
  input  logic             iCipher_serial,
  input  logic             iCipher_start,
  input  logic             iCipher_end,
  output logic             oBusy,
  output logic             oTimeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_MSG,
    S_RUN,
    S_DONE
  } state_e;

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] msg_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             capt_q;     // inside a frame (start seen, end not yet)
  logic             timeout_q;

  // A bit is captured when it is marked as start or when it falls inside an
  // open frame. An end marker that arrives outside a frame is ignored.
  logic frame_active;
  logic frame_end;
  assign frame_active = capt_q | iCipher_start;
  assign frame_end    = frame_active & iCipher_end;

`ifdef XSEQ_TIMEOUT_EN
  localparam int RCW = $clog2(TIMEOUT + 1);
  logic [RCW-1:0] run_cnt_q;
`else
  // Keeps TIMEOUT referenced when the timeout logic is not built.
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  // NOTE: Sequential state uses non-blocking assignments only. Every register
  // is therefore updated from the same pre-edge values, and simulation matches
  // the flops that synthesis builds.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      // NOTE: The reset is asynchronous. It must clear every register in this
      // block so that the strobes fall without waiting for a clock edge.
      state_q   <= S_IDLE;
      key_q     <= '0;
      msg_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      capt_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef XSEQ_TIMEOUT_EN
      run_cnt_q <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iReq_valid) begin
            key_q   <= iKey;
            msg_q   <= iMsg;
            cnt_q   <= '0;
            res_q   <= '0;
            capt_q  <= 1'b0;
            state_q <= S_LOAD_KEY;
          end
        end

        S_LOAD_KEY: begin
          key_q <= {key_q[WIDTH-2:0], 1'b0};
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= S_LOAD_MSG;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_LOAD_MSG: begin
          msg_q <= {msg_q[WIDTH-2:0], 1'b0};
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= S_RUN;
`ifdef XSEQ_TIMEOUT_EN
            run_cnt_q <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_RUN: begin
          // Shifting in every captured bit keeps the newest WIDTH bits.
          // A short frame leaves zeros in the high bits from the clear at accept.
          if (frame_active) begin
            res_q <= {res_q[WIDTH-2:0], iCipher_serial};
            if (iCipher_end) begin
              capt_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              capt_q <= 1'b1;
            end
          end
`ifdef XSEQ_TIMEOUT_EN
          if (!frame_end) begin
            if (run_cnt_q == RCW'(TIMEOUT - 1)) begin
              timeout_q <= 1'b1;
              capt_q    <= 1'b0;
              state_q   <= S_IDLE;
            end else begin
              run_cnt_q <= run_cnt_q + 1'b1;
            end
          end
`endif
        end

        S_DONE: begin
          if (iRes_ready) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Every output is decoded from registered state only. No input reaches an
  // output combinationally. Each strobe decodes a distinct state, so at most
  // one strobe is high in any cycle.
  assign oReq_ready       = (state_q == S_IDLE);
  assign oBusy            = (state_q != S_IDLE);
  assign oCipher_load_key = (state_q == S_LOAD_KEY);
  assign oCipher_load_msg = (state_q == S_LOAD_MSG);
  assign oCipher_en       = (state_q == S_RUN);
  assign oRes_valid       = (state_q == S_DONE);
  assign oRes_data        = res_q;
  assign oCipher_serial   = (state_q == S_LOAD_KEY) ? key_q[WIDTH-1] :
                            (state_q == S_LOAD_MSG) ? msg_q[WIDTH-1] : 1'b0;

`ifdef XSEQ_TIMEOUT_EN
  assign oTimeout = timeout_q;
`else
  assign oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_xor_cipher_sequencer.sv
// -----------------------------------------------------------------------------
// tb_xor_cipher_sequencer
//
// Directed self-checking bench for xor_cipher_sequencer (WIDTH=8, TIMEOUT=64).
// Inputs are driven and outputs are sampled on the falling clock edge.
// The timeout scenario is built only when XSEQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_xor_cipher_sequencer;

  localparam int W = 8;

  logic         iClk = 1'b0;
  logic         iRst;
  logic [W-1:0] iKey;
  logic [W-1:0] iMsg;
  logic         iReq_valid;
  logic         oReq_ready;
  logic [W-1:0] oRes_data;
  logic         oRes_valid;
  logic         iRes_ready;
  logic         oCipher_serial;
  logic         oCipher_load_key;
  logic         oCipher_load_msg;
  logic         oCipher_en;
  logic         iCipher_serial;
  logic         iCipher_start;
  logic         iCipher_end;
  logic         oBusy;
  logic         oTimeout;

  int n_checks = 0;
  int n_fail   = 0;

  xor_cipher_sequencer #(.WIDTH(W), .TIMEOUT(64)) dut (
    .iClk             (iClk),
    .iRst             (iRst),
    .iKey             (iKey),
    .iMsg             (iMsg),
    .iReq_valid       (iReq_valid),
    .oReq_ready       (oReq_ready),
    .oRes_data        (oRes_data),
    .oRes_valid       (oRes_valid),
    .iRes_ready       (iRes_ready),
    .oCipher_serial   (oCipher_serial),
    .oCipher_load_key (oCipher_load_key),
    .oCipher_load_msg (oCipher_load_msg),
    .oCipher_en       (oCipher_en),
    .iCipher_serial   (iCipher_serial),
    .iCipher_start    (iCipher_start),
    .iCipher_end      (iCipher_end),
    .oBusy            (oBusy),
    .oTimeout         (oTimeout)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called on a falling edge. It returns on the falling edge of cycle 1,
  // after the accept edge.
  task automatic do_request(input logic [W-1:0] key, input logic [W-1:0] msg);
    check("req_ready_before", {31'd0, oReq_ready}, 32'd1);
    iKey       = key;
    iMsg       = msg;
    iReq_valid = 1'b1;
    @(negedge iClk);
    iReq_valid = 1'b0;
    check("req_ready_after", {31'd0, oReq_ready}, 32'd0);
  endtask

  // Walks both load phases and checks the strobes and the serial bits.
  // It returns on the first falling edge of RUN.
  task automatic run_loads(input logic [W-1:0] key, input logic [W-1:0] msg);
    for (int i = 0; i < W; i++) begin
      check("lk_strobes", {29'd0, oCipher_load_key, oCipher_load_msg, oCipher_en}, 32'b100);
      check("lk_bit", {31'd0, oCipher_serial}, {31'd0, key[W-1-i]});
      @(negedge iClk);
    end
    for (int i = 0; i < W; i++) begin
      check("lm_strobes", {29'd0, oCipher_load_key, oCipher_load_msg, oCipher_en}, 32'b010);
      check("lm_bit", {31'd0, oCipher_serial}, {31'd0, msg[W-1-i]});
      @(negedge iClk);
    end
    check("run_strobes", {29'd0, oCipher_load_key, oCipher_load_msg, oCipher_en}, 32'b001);
    check("run_busy", {31'd0, oBusy}, 32'd1);
  endtask

  // Drives an n-bit frame MSB first. The start marker is on the first bit and
  // the end marker is on the last bit.
  task automatic send_frame(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      iCipher_serial = bits[i];
      iCipher_start  = (i == n - 1);
      iCipher_end    = (i == 0);
      @(negedge iClk);
    end
    iCipher_serial = 1'b0;
    iCipher_start  = 1'b0;
    iCipher_end    = 1'b0;
  endtask

  task automatic take_result(input logic [W-1:0] exp);
    check("res_valid", {31'd0, oRes_valid}, 32'd1);
    check("res_data", {24'd0, oRes_data}, {24'd0, exp});
    iRes_ready = 1'b1;
    @(negedge iClk);
    iRes_ready = 1'b0;
    check("idle_ready", {31'd0, oReq_ready}, 32'd1);
    check("idle_valid", {31'd0, oRes_valid}, 32'd0);
    check("idle_busy", {31'd0, oBusy}, 32'd0);
  endtask

  initial begin
    iRst           = 1'b1;
    iKey           = '0;
    iMsg           = '0;
    iReq_valid     = 1'b0;
    iRes_ready     = 1'b0;
    iCipher_serial = 1'b0;
    iCipher_start  = 1'b0;
    iCipher_end    = 1'b0;

    // Reset state
    #2;
    check("rst_outputs",
          {25'd0, oReq_ready, oRes_valid, oCipher_serial, oCipher_load_key,
           oCipher_load_msg, oCipher_en, oBusy},
          32'b1000000);
    check("rst_data", {24'd0, oRes_data}, 32'd0);
    check("rst_timeout", {31'd0, oTimeout}, 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);

    // Nominal transfer: 0xA5 ^ 0x3C = 0x99.
    // Backpressure follows: a new request is ignored while the result is pending.
    do_request(8'hA5, 8'h3C);
    run_loads(8'hA5, 8'h3C);
    send_frame(16'h0099, 8);
    iReq_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, oRes_valid}, 32'd1);
      check("bp_data", {24'd0, oRes_data}, 32'h99);
      check("bp_req_ready", {31'd0, oReq_ready}, 32'd0);
      @(negedge iClk);
    end
    iReq_valid = 1'b0;
    take_result(8'h99);

    // An end marker with no start is ignored. Then a one-bit frame follows.
    @(negedge iClk);
    do_request(8'h01, 8'h02);
    run_loads(8'h01, 8'h02);
    iCipher_end = 1'b1;
    iCipher_serial = 1'b1;
    @(negedge iClk);
    iCipher_end = 1'b0;
    iCipher_serial = 1'b0;
    check("lone_end_ignored", {31'd0, oRes_valid}, 32'd0);
    check("lone_end_en", {31'd0, oCipher_en}, 32'd1);
    send_frame(16'h0001, 1);
    take_result(8'h01);

    // Long frame of 10 bits, 1100000001. Only the last 8 bits are kept, giving 0x01.
    do_request(8'hFF, 8'h00);
    run_loads(8'hFF, 8'h00);
    send_frame(16'b1100000001, 10);
    take_result(8'h01);

    // Three-bit frame 101. The high bits are zero-extended, giving 0x05.
    do_request(8'h5A, 8'hC3);
    run_loads(8'h5A, 8'hC3);
    send_frame(16'b101, 3);
    take_result(8'h05);

    // Asynchronous reset in the middle of LOAD_MSG
    do_request(8'h81, 8'h7E);
    repeat (W + 2) @(negedge iClk);
    check("pre_rst_load_msg", {31'd0, oCipher_load_msg}, 32'd1);
    #1 iRst = 1'b1;
    #1;
    check("arst_strobes", {29'd0, oCipher_load_key, oCipher_load_msg, oCipher_en}, 32'd0);
    check("arst_ready", {31'd0, oReq_ready}, 32'd1);
    @(negedge iClk);
    iRst = 1'b0;
    check("arst_timeout", {31'd0, oTimeout}, 32'd0);
    check("arst_valid", {31'd0, oRes_valid}, 32'd0);
    @(negedge iClk);
    do_request(8'h0F, 8'hF0);
    run_loads(8'h0F, 8'hF0);
    send_frame(16'h00FF, 8);
    take_result(8'hFF);

`ifdef XSEQ_TIMEOUT_EN
    // Timeout: the core never starts a frame
    begin
      int  cycles;
      bit  got;
      bit  saw_valid;
      cycles    = 0;
      got       = 1'b0;
      saw_valid = 1'b0;
      do_request(8'h12, 8'h34);
      run_loads(8'h12, 8'h34);
      for (int i = 0; i < 200 && !got; i++) begin
        if (oTimeout) got = 1'b1;
        else begin
          if (oCipher_en) cycles++;
          if (oRes_valid) saw_valid = 1'b1;
          @(negedge iClk);
        end
      end
      check("to_seen", {31'd0, got}, 32'd1);
      check("to_run_cycles", cycles, 32'd64);
      check("to_ready", {31'd0, oReq_ready}, 32'd1);
      check("to_no_valid", {31'd0, saw_valid}, 32'd0);
      @(negedge iClk);
      check("to_one_pulse", {31'd0, oTimeout}, 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_cipher_sequencer.md
# xor_cipher_sequencer

Front-end controller for the serial XOR cipher core. Accepts a parallel key/message pair over a valid/ready handshake and shifts the key into the core, then the message. It then enables the core, deserializes the core's framed serial output into a parallel result, and presents that result over a second valid/ready handshake. It sits between the bus-side register logic and the cipher core, and it is the only block that drives the core's load and enable strobes.

## Interface
- `WIDTH`, default 8: bits per key, message and result.
- `TIMEOUT`, default 64: maximum RUN cycles to wait for end of frame. Used only when `XSEQ_TIMEOUT_EN` is defined.

- `iClk`, in, 1: clock. All logic is rising-edge.
- `iRst`, in, 1: reset, asynchronous, active-high.
- `iKey`, in, WIDTH: key. Sampled on request accept.
- `iMsg`, in, WIDTH: message. Sampled on request accept.
- `iReq_valid`, in, 1: request valid.
- `oReq_ready`, out, 1: high only in IDLE.
- `oRes_data`, out, WIDTH: result word.
- `oRes_valid`, out, 1: result valid. High in DONE.
- `iRes_ready`, in, 1: consumer accepts the result.
- `oCipher_serial`, out, 1: serial bit to the core, MSB first.
- `oCipher_load_key`, out, 1: key-load strobe to the core.
- `oCipher_load_msg`, out, 1: message-load strobe to the core.
- `oCipher_en`, out, 1: core enable.
- `iCipher_serial`, in, 1: core serial output.
- `iCipher_start`, in, 1: core first-bit marker.
- `iCipher_end`, in, 1: core last-bit marker.
- `oBusy`, out, 1: high in any state other than IDLE.
- `oTimeout`, out, 1: one-cycle pulse on abort.

## Operation
- States: IDLE, LOAD_KEY, LOAD_MSG, RUN, DONE. Encoding is free.
- IDLE: `oReq_ready`=1. When `iReq_valid` is high at a rising edge:
  - capture `iKey` and `iMsg` into shift registers;
  - clear the bit counter and the result register;
  - go to LOAD_KEY.
- LOAD_KEY: `oCipher_load_key`=1 and `oCipher_serial`=key MSB. Shift left every cycle. After exactly WIDTH cycles, go to LOAD_MSG.
- LOAD_MSG: same as LOAD_KEY, but with `oCipher_load_msg` and the message register. After WIDTH cycles, go to RUN.
- RUN: `oCipher_en`=1. Capture is active from the cycle `iCipher_start` is high through the cycle `iCipher_end` is high, inclusive. Each active cycle, result = {result[WIDTH-2:0], `iCipher_serial`}.
  - More than WIDTH captured bits: only the last WIDTH bits are kept.
  - Fewer than WIDTH bits: the result is zero-extended in the high bits.
  - `iCipher_end` before any `iCipher_start`: ignored.
  - `iCipher_start` and `iCipher_end` in the same cycle: one-bit frame.
  - When `iCipher_end` is captured, go to DONE.
- DONE: `oRes_valid`=1 and `oRes_data` is held stable. When `iRes_ready` is high, go to IDLE.
- No request is accepted while a result is pending. One transaction is in flight at most.
- The load and enable strobes are mutually exclusive. At most one of them is high in any cycle.

## Timing
- Reset values (asynchronous, take effect immediately): state=IDLE and every output is 0, except `oReq_ready`=1. Shift registers, counters and `oRes_data` are also 0.
- Request accepted at edge 0:
  - `oCipher_load_key` is high for cycles 1..WIDTH;
  - `oCipher_load_msg` is high for cycles WIDTH+1..2·WIDTH;
  - `oCipher_en` goes high from cycle 2·WIDTH+1.
- `oRes_valid` rises the cycle after `iCipher_end` is captured.
- `oReq_ready` rises the cycle after the result handshake.
- All outputs are registered or decoded directly from state. There are no combinational paths from inputs to outputs.
- Reset mid-operation aborts the transaction. No result and no timeout pulse are produced.

## Configuration
- `XSEQ_TIMEOUT_EN` defined:
  - a RUN-cycle counter starts at 0 on entry to RUN;
  - if the counter reaches TIMEOUT without a captured `iCipher_end`, `oTimeout` pulses for one cycle and the state goes to IDLE;
  - `oRes_valid` is not asserted for that transaction.
- `XSEQ_TIMEOUT_EN` undefined:
  - RUN waits indefinitely;
  - `oTimeout` is tied to 0;
  - the counter is not built.

## Test plan
- Nominal transfer: key 0xA5, msg 0x3C, core model returns an 8-bit frame of key^msg. Required: `oCipher_serial` during load_key is 1,0,1,0,0,1,0,1; load_msg is high for exactly 8 cycles; `oRes_data`=0x99 with `oRes_valid`.
- Backpressure: hold `iRes_ready` low for 5 cycles after `oRes_valid`. Required: data stays 0x99; `oReq_ready`=0 and `iReq_valid` is ignored throughout; IDLE is reached the cycle after `iRes_ready`.
- Short frame: `iCipher_start` and `iCipher_end` in the same cycle with serial=1. Required: `oRes_data`=0x01.
- Long frame: 10 bits 1,1,0,0,0,0,0,0,0,1. Required: `oRes_data`=0x01, since the leading bits are dropped.
- Timeout (macro defined, TIMEOUT=64): core never asserts start. Required: `oTimeout` is a single pulse after 64 RUN cycles; `oRes_valid` never rises; `oReq_ready`=1 the next cycle.
- Reset mid-LOAD_MSG: assert `iRst` asynchronously. Required: all strobes go to 0 with no clock edge; `oReq_ready`=1 after release; a new request then completes normally.
